irq_moderator: RTL and testbench
================================

# irq_moderator

Interrupt moderation stage feeding `irq_gen`. It counts completion events posted by the RX DMA engine, subtracts events the host reports as consumed, and drives the level `send_irq` once a batch threshold or a timeout is reached. `irq_gen` handles endpoint arbitration and MSI signalling, with its own `irq_thr` hold-off between interrupts. This block only decides *whether* an interrupt is warranted.

## Interface
Parameters:
- `CNT_W`, 16, width of the pending-event counter and `pkt_thr`
- `TMR_W`, 24, width of the moderation timer and `tmr_thr`

Ports:
- `clk`  in  1  core clock; all logic on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `evt_valid`  in  1  one-cycle pulse; one new event completed to host memory
- `hst_cons_wr`  in  1  one-cycle pulse; host wrote its consumed count
- `hst_cons_cnt`  in  CNT_W  number of events consumed, valid with `hst_cons_wr`
- `mod_en`  in  1  1 = moderate (batch/timeout); 0 = fire as soon as pending > 0
- `pkt_thr`  in  CNT_W  batch threshold; 0 treated as 1
- `tmr_thr`  in  TMR_W  timeout in cycles after the state reaches ARMED
- `send_irq`  out  1  level request to `irq_gen`
- `pending`  out  CNT_W  registered pending-event count
- `cnt_ovf`  out  1  sticky; an increment was dropped because `pending` was saturated
- `cnt_udf`  out  1  sticky; host consumed more events than were pending

## Operation
- Next pending count: `pending + evt_valid − (hst_cons_wr ? hst_cons_cnt : 0)`, computed at CNT_W+2 bits signed.
  - Result < 0: clamp to 0 and set `cnt_udf`.
  - Result > 2^CNT_W−1: hold at max and set `cnt_ovf`.
  - A simultaneous event and consume are both applied in the same cycle.
- Fire condition `fc`: `!mod_en` OR `pending >= max(pkt_thr,1)` OR `tmr == tmr_thr`. `fc` is evaluated on registered `pending` and `tmr`.
- FSM states:
  - IDLE: `send_irq`=0, `tmr`=0. If `pending`>0 and `fc`, go to FIRE. If `pending`>0 and not `fc`, go to ARMED.
  - ARMED: `tmr` increments each cycle, saturating at all-ones. If `pending`==0 (host drained the events), go to IDLE. Otherwise if `fc`, go to FIRE.
  - FIRE: `send_irq`=1, `tmr` held at 0. If `pending`==0, go to IDLE. Partial consumption keeps the state in FIRE; `irq_gen`'s hold-off limits the interrupt rate.
- Unreachable state encodings go to IDLE.
- `send_irq` is a registered Moore output: it is 1 exactly while the state is FIRE.
- `pkt_thr`, `tmr_thr` and `mod_en` are quasi-static. A change takes effect on the next `fc` evaluation; no restart is needed.

## Timing
- Reset values: `send_irq`=0, `pending`=0, `cnt_ovf`=0, `cnt_udf`=0, state IDLE, `tmr`=0.
- Reset asserted mid-operation clears everything immediately, including the sticky flags.
- `evt_valid` at cycle N gives `pending`=1 at N+1. The state changes at N+2 (FIRE if `fc`, otherwise ARMED).
- Timeout path: ARMED entered at cycle A with `tmr`=0. `tmr` equals `tmr_thr` at A+`tmr_thr`, and `send_irq` rises at A+`tmr_thr`+1.
- `hst_cons_wr` that drains `pending` to 0 at cycle M gives `pending`=0 at M+1. `send_irq` falls at M+2.
- Worst-case latency from the first event to `send_irq` with `mod_en`=0 is 2 cycles.

## Structure
- Shared package `irq_mod_pkg`:
  - state encodings for IDLE, ARMED and FIRE, one-hot, 3 bits
  - default widths `CNT_W_DEF` and `TMR_W_DEF`
- One sub-module, `sat_updown_cnt`: a CNT_W saturating up/down counter that outputs clamped count, `ovf` pulse and `udf` pulse. The sticky flags live in the parent.
- The FSM and timer are in the top module.

## Test plan
- `mod_en`=0, single `evt_valid` at cycle 10 -> `pending`=1 at 11, `send_irq`=1 at 12. `hst_cons_wr` with count 1 at 20 -> `send_irq`=0 at 22.
- `mod_en`=1, `pkt_thr`=4, `tmr_thr`=1000, events at cycles 10–13 -> `pending`=4 at 14, `send_irq` rises at 15, no earlier.
- `mod_en`=1, `pkt_thr`=8, `tmr_thr`=100, single event at 10 -> ARMED at 12, `send_irq` rises at 113.
- Event and `hst_cons_wr` (count 1) in the same cycle with `pending`=3 -> `pending` stays 3. Consume 5 with `pending`=3 -> `pending`=0, `cnt_udf`=1.
- `CNT_W`=4, 17 events with no consumption -> `pending`=15, `cnt_ovf`=1. `rst_n` pulsed low mid-burst -> all outputs 0 asynchronously.
- ARMED with `pending`=2, then host consumes 2 before timeout -> return to IDLE, `send_irq` never asserted, `tmr` back to 0.

Source files
------------

// File: rtl/irq_mod_pkg.sv
// Shared encodings and default widths for the interrupt moderation stage.
// No logic; imported by irq_moderator and its bench.
package irq_mod_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int TMR_W_DEF = 24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_ARMED = 3'b010,
        ST_FIRE  = 3'b100
    } state_t;

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter: +1 on inc, -dec_cnt on dec, clamped to [0, 2^W-1].
// Count registered (1 cycle); ovf/udf are same-cycle combinational pulses; no backpressure.
module sat_updown_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic [W-1:0] dec_cnt,
    output logic [W-1:0] cnt,
    output logic         ovf,
    output logic         udf
);

    logic [W+1:0] dec_amt;
    logic [W+1:0] sum;
    logic [W-1:0] cnt_nxt;

    // Two guard bits: bit W+1 flags a negative result, bit W an overflow.
    always_comb begin
        dec_amt = dec ? {2'b00, dec_cnt} : '0;
        sum     = {2'b00, cnt} + {{(W+1){1'b0}}, inc} - dec_amt;
        cnt_nxt = sum[W-1:0];
        ovf     = 1'b0;
        udf     = 1'b0;
        if (sum[W+1]) begin
            cnt_nxt = '0;
            udf     = 1'b1;
        end else if (sum[W]) begin
            cnt_nxt = '1;
            ovf     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/irq_moderator.sv
// Decides when an interrupt is warranted: batch threshold, timeout, or immediate when unmoderated.
// send_irq is a registered Moore output, 2 cycles after the first event at best; no backpressure.
module irq_moderator
    import irq_mod_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TMR_W = TMR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             evt_valid,
    input  logic             hst_cons_wr,
    input  logic [CNT_W-1:0] hst_cons_cnt,
    input  logic             mod_en,
    input  logic [CNT_W-1:0] pkt_thr,
    input  logic [TMR_W-1:0] tmr_thr,
    output logic             send_irq,
    output logic [CNT_W-1:0] pending,
    output logic             cnt_ovf,
    output logic             cnt_udf
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0] TMR_ONE = {{(TMR_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [TMR_W-1:0] tmr;
    logic             ovf_p;
    logic             udf_p;
    logic [CNT_W-1:0] thr_eff;
    logic             has_pend;
    logic             fc;

    sat_updown_cnt #(.W(CNT_W)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (evt_valid),
        .dec     (hst_cons_wr),
        .dec_cnt (hst_cons_cnt),
        .cnt     (pending),
        .ovf     (ovf_p),
        .udf     (udf_p)
    );

    // A zero threshold would otherwise fire with nothing pending; treat it as 1.
    always_comb begin
        thr_eff  = (pkt_thr == '0) ? CNT_ONE : pkt_thr;
        has_pend = (pending != '0);
        fc       = !mod_en || (pending >= thr_eff) || (tmr == tmr_thr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_ovf <= 1'b0;
            cnt_udf <= 1'b0;
        end else begin
            if (ovf_p) cnt_ovf <= 1'b1;
            if (udf_p) cnt_udf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tmr      <= '0;
            send_irq <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tmr <= '0;
                    if (has_pend && fc) begin
                        state    <= ST_FIRE;
                        send_irq <= 1'b1;
                    end else if (has_pend) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (tmr != '1) tmr <= tmr + TMR_ONE;
                    if (!has_pend) begin
                        state <= ST_IDLE;
                        tmr   <= '0;
                    end else if (fc) begin
                        state    <= ST_FIRE;
                        tmr      <= '0;
                        send_irq <= 1'b1;
                    end
                end
                ST_FIRE: begin
                    // Stay here on partial consumption; irq_gen paces repeats.
                    tmr <= '0;
                    if (!has_pend) begin
                        state    <= ST_IDLE;
                        send_irq <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    tmr      <= '0;
                    send_irq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_moderator.sv
// Directed bench for irq_moderator: default widths plus a CNT_W=4 instance for saturation.
module tb_irq_moderator;
    import irq_mod_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        evt_valid = 1'b0;
    logic        hst_cons_wr = 1'b0;
    logic [15:0] hst_cons_cnt = '0;
    logic        mod_en = 1'b0;
    logic [15:0] pkt_thr = 16'd1;
    logic [23:0] tmr_thr = 24'd1000;
    logic        send_irq;
    logic [15:0] pending;
    logic        cnt_ovf;
    logic        cnt_udf;

    logic        evt4 = 1'b0;
    logic        cons4_wr = 1'b0;
    logic [3:0]  cons4_cnt = '0;
    logic        mod4_en = 1'b1;
    logic [3:0]  thr4 = '0;
    logic [23:0] tthr4 = 24'd1000;
    logic        send4;
    logic [3:0]  pend4;
    logic        ovf4;
    logic        udf4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    irq_moderator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .evt_valid    (evt_valid),
        .hst_cons_wr  (hst_cons_wr),
        .hst_cons_cnt (hst_cons_cnt),
        .mod_en       (mod_en),
        .pkt_thr      (pkt_thr),
        .tmr_thr      (tmr_thr),
        .send_irq     (send_irq),
        .pending      (pending),
        .cnt_ovf      (cnt_ovf),
        .cnt_udf      (cnt_udf)
    );

    irq_moderator #(.CNT_W(4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .evt_valid    (evt4),
        .hst_cons_wr  (cons4_wr),
        .hst_cons_cnt (cons4_cnt),
        .mod_en       (mod4_en),
        .pkt_thr      (thr4),
        .tmr_thr      (tthr4),
        .send_irq     (send4),
        .pending      (pend4),
        .cnt_ovf      (ovf4),
        .cnt_udf      (udf4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic consume(input logic [15:0] n);
        hst_cons_wr  = 1'b1;
        hst_cons_cnt = n;
        tick();
        hst_cons_wr  = 1'b0;
        hst_cons_cnt = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (send_irq !== 1'b0) begin n_err++; $display("FAIL reset_send got %b want 0", send_irq); end
        n_cmp++; if (pending !== 16'd0) begin n_err++; $display("FAIL reset_pending got %0d want 0", pending); end
        n_cmp++; if ({cnt_ovf, cnt_udf} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {cnt_ovf, cnt_udf}); end
        n_cmp++; if (dut.state !== ST_IDLE) begin n_err++; $display("FAIL reset_state got %b want %b", dut.state, ST_IDLE); end
        n_cmp++; if (dut.tmr !== 24'd0) begin n_err++; $display("FAIL reset_tmr got %0d want 0", dut.tmr); end
    endtask

    task automatic test_unmoderated();
        mod_en = 1'b0;
        evt_valid = 1'b1;
        tick();
        evt_valid = 1'b0;
        n_cmp++; if (pending !== 16'd1) begin n_err++; $display("FAIL unmod_pending got %0d want 1", pending); end
        n_cmp++; if (send_irq !== 1'b0) begin n_err++; $display("FAIL unmod_send_n1 got %b want 0", send_irq); end
        tick();
        n_cmp++; if (send_irq !== 1'b1) begin n_err++; $display("FAIL unmod_send_n2 got %b want 1", send_irq); end
        repeat (6) tick();
        consume(16'd1);
        n_cmp++; if (pending !== 16'd0 || send_irq !== 1'b1) begin n_err++; $display("FAIL unmod_drain_m1 got pend=%0d send=%b want 0/1", pending, send_irq); end
        tick();
        n_cmp++; if (send_irq !== 1'b0) begin n_err++; $display("FAIL unmod_drain_m2 got %b want 0", send_irq); end
    endtask

    task automatic test_batch();
        mod_en = 1'b1;
        pkt_thr = 16'd4;
        tmr_thr = 24'd1000;
        evt_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++; if (pending !== 16'(i) || send_irq !== 1'b0) begin n_err++; $display("FAIL batch_step%0d got pend=%0d send=%b want %0d/0", i, pending, send_irq, i); end
        end
        evt_valid = 1'b0;
        tick();
        n_cmp++; if (send_irq !== 1'b1) begin n_err++; $display("FAIL batch_fire got %b want 1", send_irq); end
        consume(16'd4);
        tick();
        n_cmp++; if (send_irq !== 1'b0) begin n_err++; $display("FAIL batch_clear got %b want 0", send_irq); end
    endtask

    task automatic test_timeout();
        logic early;
        mod_en = 1'b1;
        pkt_thr = 16'd8;
        tmr_thr = 24'd100;
        evt_valid = 1'b1;
        tick();
        evt_valid = 1'b0;
        tick();
        n_cmp++; if (dut.state !== ST_ARMED || dut.tmr !== 24'd0) begin n_err++; $display("FAIL tmo_armed got st=%b tmr=%0d want %b/0", dut.state, dut.tmr, ST_ARMED); end
        early = 1'b0;
        repeat (100) begin
            tick();
            if (send_irq !== 1'b0) early = 1'b1;
        end
        n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL tmo_early got 1 want 0"); end
        n_cmp++; if (dut.tmr !== 24'd100) begin n_err++; $display("FAIL tmo_tmr got %0d want 100", dut.tmr); end
        tick();
        n_cmp++; if (send_irq !== 1'b1) begin n_err++; $display("FAIL tmo_fire got %b want 1", send_irq); end
        consume(16'd1);
        tick();
    endtask

    task automatic test_thr_zero();
        mod_en = 1'b1;
        pkt_thr = 16'd0;
        tmr_thr = 24'd1000;
        evt_valid = 1'b1;
        tick();
        evt_valid = 1'b0;
        tick();
        n_cmp++; if (send_irq !== 1'b1) begin n_err++; $display("FAIL thr0_fire got %b want 1", send_irq); end
        consume(16'd1);
        tick();
    endtask

    task automatic test_back_to_back();
        mod_en = 1'b1;
        pkt_thr = 16'd100;
        tmr_thr = 24'd1000;
        evt_valid = 1'b1;
        repeat (3) tick();
        n_cmp++; if (pending !== 16'd3) begin n_err++; $display("FAIL b2b_fill got %0d want 3", pending); end
        hst_cons_wr = 1'b1;
        hst_cons_cnt = 16'd1;
        tick();
        evt_valid = 1'b0;
        n_cmp++; if (pending !== 16'd3 || cnt_udf !== 1'b0) begin n_err++; $display("FAIL b2b_both got pend=%0d udf=%b want 3/0", pending, cnt_udf); end
        hst_cons_cnt = 16'd5;
        tick();
        hst_cons_wr = 1'b0;
        hst_cons_cnt = '0;
        n_cmp++; if (pending !== 16'd0 || cnt_udf !== 1'b1 || cnt_ovf !== 1'b0) begin n_err++; $display("FAIL b2b_udf got pend=%0d udf=%b ovf=%b want 0/1/0", pending, cnt_udf, cnt_ovf); end
        repeat (2) tick();
        n_cmp++; if (cnt_udf !== 1'b1 || send_irq !== 1'b0) begin n_err++; $display("FAIL b2b_sticky got udf=%b send=%b want 1/0", cnt_udf, send_irq); end
        do_reset();
        n_cmp++; if (cnt_udf !== 1'b0) begin n_err++; $display("FAIL b2b_rst_udf got %b want 0", cnt_udf); end
    endtask

    task automatic test_drain_armed();
        logic seen;
        mod_en = 1'b1;
        pkt_thr = 16'd8;
        tmr_thr = 24'd100;
        seen = 1'b0;
        evt_valid = 1'b1;
        repeat (2) tick();
        evt_valid = 1'b0;
        repeat (5) begin
            tick();
            if (send_irq !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (dut.state !== ST_ARMED || pending !== 16'd2 || dut.tmr === 24'd0) begin n_err++; $display("FAIL drain_armed got st=%b pend=%0d tmr=%0d want ARMED/2/>0", dut.state, pending, dut.tmr); end
        consume(16'd2);
        if (send_irq !== 1'b0) seen = 1'b1;
        n_cmp++; if (pending !== 16'd0) begin n_err++; $display("FAIL drain_pend got %0d want 0", pending); end
        tick();
        if (send_irq !== 1'b0) seen = 1'b1;
        n_cmp++; if (dut.state !== ST_IDLE || dut.tmr !== 24'd0) begin n_err++; $display("FAIL drain_idle got st=%b tmr=%0d want %b/0", dut.state, dut.tmr, ST_IDLE); end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL drain_noirq got 1 want 0"); end
    endtask

    task automatic test_overflow();
        evt4 = 1'b1;
        repeat (15) tick();
        n_cmp++; if (pend4 !== 4'd15 || ovf4 !== 1'b0) begin n_err++; $display("FAIL ovf_full got pend=%0d ovf=%b want 15/0", pend4, ovf4); end
        repeat (2) tick();
        n_cmp++; if (pend4 !== 4'd15 || ovf4 !== 1'b1) begin n_err++; $display("FAIL ovf_sat got pend=%0d ovf=%b want 15/1", pend4, ovf4); end
        n_cmp++; if (send4 !== 1'b1) begin n_err++; $display("FAIL ovf_send got %b want 1", send4); end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (pend4 !== 4'd0 || ovf4 !== 1'b0 || send4 !== 1'b0 || udf4 !== 1'b0) begin n_err++; $display("FAIL async_rst got pend=%0d ovf=%b send=%b udf=%b want 0/0/0/0", pend4, ovf4, send4, udf4); end
        evt4 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_unmoderated();
        test_batch();
        test_timeout();
        test_thr_zero();
        test_back_to_back();
        test_drain_armed();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
